seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed scan driver for the 8-digit common-anode seven-segment display. It generates the active-low digit selects that the counter/value blocks decode to place a 4-bit digit value on `num`. It registers that value, decodes it to active-low segment patterns and drives the anodes and segments directly. A segment-blanking window at every digit change suppresses ghosting.

## Interface
- `SCAN_DIV`, default 200000: clock cycles per digit slot; must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 1000: blanking cycles at the start of each slot; must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `en_mask`  in  8  per-digit enable; bit i=1 means digit i is displayed. Sampled at slot boundaries.
- `dp_mask`  in  8  per-digit decimal point; bit i=1 lights dp on digit i.
- `num`  in  4  digit value returned by the value source for the currently selected digit. Combinational response to `dig_sel`.
- `dig_sel`  out  8  active-low digit select; drives both the display anodes and the value source's `en` inputs. At most one bit is low.
- `seg`  out  8  active-low segments, {dp,g,f,e,d,c,b,a}.
- `frame_tick`  out  1  one-cycle pulse in the first cycle of every digit-0 slot.

## Operation
- State: slot counter `cnt` (0..SCAN_DIV-1), digit index `idx` (0..7), phase BLANK (`cnt` < BLANK_CYC) or SHOW (otherwise).
- Reset values: `idx`=7, `cnt`=SCAN_DIV-1, `dig_sel`=8'hFF, `seg`=8'hFF, `frame_tick`=0.
- Each cycle: if `cnt`==SCAN_DIV-1, then `cnt`←0, `idx`←`idx`+1 (7 wraps to 0), `dig_sel`←`en_mask`[next idx] ? ~(1<<next idx) : 8'hFF. Otherwise `cnt`←`cnt`+1.
- `en_mask` is used only at that boundary. A change mid-slot has no effect until the next slot.
- BLANK phase: `seg`←8'hFF. `dig_sel` already points at the new digit, so the value source settles `num`.
- SHOW phase with the digit enabled: `seg`[6:0]←decode(`num`), `seg`[7]←~`dp_mask`[`idx`]. `num` and `dp_mask` are re-sampled every cycle, so live updates appear with 1-cycle latency.
- SHOW phase with the digit disabled: `seg` stays 8'hFF and `dig_sel` stays 8'hFF for the whole slot. Slot length is fixed, so brightness does not depend on the enable count. With `en_mask`=0 the display is fully dark.
- `frame_tick`←1 in the cycle `idx` becomes 0, otherwise 0. This includes the first cycle after reset release.
- Decode, 8-bit `seg` values with dp off: 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E.
- Reset asserted mid-slot: on the next edge all state returns to reset values. `dig_sel` and `seg` go to 8'hFF in that same cycle.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- First edge with `rst`=0: slot 0 begins, `dig_sel` loaded for digit 0, `frame_tick`=1.
- Slot k occupies SCAN_DIV cycles. `seg` is 8'hFF for cycles 0..BLANK_CYC of the slot. The first decoded value appears on the edge after `cnt` reaches BLANK_CYC, i.e. 1 cycle of decode latency.
- `seg` returns to 8'hFF on the first cycle of the next slot, coincident with the `dig_sel` change. Segments are never driven while anodes switch.
- Frame period = 8×SCAN_DIV cycles. `frame_tick` period is identical.

## Test plan
- SCAN_DIV=10, BLANK_CYC=3, `en_mask`=FF, reset released: `dig_sel` sequences FE, FD, FB, … 7F, FE, each held exactly 10 cycles. `frame_tick` is high on the first cycle and every 80 cycles after.
- Same setup, `num` model returns digit index (digit i → i), `dp_mask`=0: during each SHOW window `seg` equals the decode table (digit 2 → A4, digit 7 → F8). `seg`=FF for the first 4 cycles of every slot.
- `en_mask`=8'b0000_0101, `num`=8: only digits 0 and 2 are selected (FE then FB). In all other slots `dig_sel`=FF and `seg`=FF, with slot length still 10.
- `dp_mask`=8'h01, `num`=0: digit 0 shows `seg`=40, all other digits show C0.
- Toggle `en_mask` bit 3 mid-slot 3: the current slot is unaffected and the change takes effect only at the next slot-3 boundary. Sweep `num` 0..F mid-SHOW: `seg` follows one cycle later.
- Assert `rst` during the SHOW phase of slot 5: the next edge gives `dig_sel`=FF and `seg`=FF. After release, scanning restarts at digit 0 with a `frame_tick` pulse.

Source files
------------

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Scan driver for an 8-digit common-anode seven-segment display.
//                It multiplexes the active-low digit selects, decodes the
//                returned digit value and blanks the segments at the start
//                of every slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV  = 200000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] en_mask,
    input  logic [7:0] dp_mask,
    input  logic [3:0] num,
    output logic [7:0] dig_sel,
    output logic [7:0] seg,
    output logic       frame_tick
);

    localparam int                 c_CNT_W     = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_END = c_CNT_W'(BLANK_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_dig_sel;
    logic [7:0]         r_seg;
    logic               r_frame_tick;

    logic [2:0]         w_idx_next;
    logic               w_dig_on;
    logic [6:0]         w_dec;

    assign w_idx_next = r_idx + 3'd1;
    // A disabled slot leaves every anode off, so the select itself is the enable.
    assign w_dig_on   = ~&r_dig_sel;

    always_comb begin
        w_dec = 7'h7F;
        case (num)
            4'h0: w_dec = 7'h40;
            4'h1: w_dec = 7'h79;
            4'h2: w_dec = 7'h24;
            4'h3: w_dec = 7'h30;
            4'h4: w_dec = 7'h19;
            4'h5: w_dec = 7'h12;
            4'h6: w_dec = 7'h02;
            4'h7: w_dec = 7'h78;
            4'h8: w_dec = 7'h00;
            4'h9: w_dec = 7'h10;
            4'hA: w_dec = 7'h08;
            4'hB: w_dec = 7'h03;
            4'hC: w_dec = 7'h46;
            4'hD: w_dec = 7'h21;
            4'hE: w_dec = 7'h06;
            4'hF: w_dec = 7'h0E;
            default: w_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= c_CNT_LAST;
            r_idx        <= 3'd7;
            r_dig_sel    <= 8'hFF;
            r_seg        <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else if (r_cnt == c_CNT_LAST) begin
            // Slot boundary: segments go dark in the same cycle the anode moves.
            r_cnt        <= '0;
            r_idx        <= w_idx_next;
            r_dig_sel    <= en_mask[w_idx_next] ? ~(8'h01 << w_idx_next) : 8'hFF;
            r_seg        <= 8'hFF;
            r_frame_tick <= (w_idx_next == 3'd0);
        end else begin
            r_cnt        <= r_cnt + c_CNT_ONE;
            r_frame_tick <= 1'b0;
            if ((r_cnt >= c_BLANK_END) && w_dig_on) begin
                r_seg <= {~dp_mask[r_idx], w_dec};
            end else begin
                r_seg <= 8'hFF;
            end
        end
    end

    assign dig_sel    = r_dig_sel;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
